// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
//   FWD_*      : operand-select encodings for the execute-stage forwarding muxes
//   CNT_W      : width of the MDU occupancy down-counter
//   hz_state_t : hazard controller FSM states
package mips_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
    localparam logic [1:0] FWD_WB  = 2'b01;  // result from writeback
    localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result from memory stage

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        RUN = 1'b0,
        MDU = 1'b1
    } hz_state_t;

endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding selects for the execute operand muxes and the
// decode-stage branch comparator.
//   RsD/RtD, RsE/RtE          : source specifiers in decode / execute
//   WriteRegM/W, RegWriteM/W  : destination specifier and write enable in M / W
//   ForwardAE/BE              : execute select (FWD_MEM beats FWD_WB beats FWD_RF)
//   ForwardAD/BD              : 1 = decode compare takes the ALU result from M
module forward_unit
    import mips_pkg::*;
#(
    parameter int unsigned REG_ADDR = 5
) (
    input  logic [REG_ADDR-1:0] RsD,
    input  logic [REG_ADDR-1:0] RtD,
    input  logic [REG_ADDR-1:0] RsE,
    input  logic [REG_ADDR-1:0] RtE,
    input  logic [REG_ADDR-1:0] WriteRegM,
    input  logic [REG_ADDR-1:0] WriteRegW,
    input  logic                RegWriteM,
    input  logic                RegWriteW,
    output logic [1:0]          ForwardAE,
    output logic [1:0]          ForwardBE,
    output logic                ForwardAD,
    output logic                ForwardBD
);

    // Register $zero is never a real producer, so it never matches.
    function automatic logic hit(input logic [REG_ADDR-1:0] dst,
                                 input logic [REG_ADDR-1:0] src);
        return (dst != '0) && (dst == src);
    endfunction

    // Execute selects: the younger (M) producer wins over W.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (RegWriteM && hit(WriteRegM, RsE))      ForwardAE = FWD_MEM;
        else if (RegWriteW && hit(WriteRegW, RsE)) ForwardAE = FWD_WB;
        if (RegWriteM && hit(WriteRegM, RtE))      ForwardBE = FWD_MEM;
        else if (RegWriteW && hit(WriteRegW, RtE)) ForwardBE = FWD_WB;
    end

    assign ForwardAD = RegWriteM && hit(WriteRegM, RsD);
    assign ForwardBD = RegWriteM && hit(WriteRegM, RtD);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Generates PC / IF/ID / ID/EX stall and clear controls, forwarding selects,
// MDU occupancy sequencing and a free-running stall-cycle counter.
//   CLK, RST                      : clock, synchronous active-high reset
//   RsD/RtD/RsE/RtE               : source specifiers in decode / execute
//   WriteReg*/RegWrite*           : destination specifier / write enable per stage
//   MemtoRegE/M                   : load in E / M
//   BranchD, BranchTakenD         : branch in decode and its resolution
//   MduStartE                     : mult/div issuing in execute
//   ImemReadyF                    : instruction memory has valid data
//   StallF/StallD/FlushD/FlushE   : front-end stall and clear controls
//   ForwardAE/BE/AD/BD            : forwarding selects
//   MduBusy                       : MDU stall window active
//   StallCnt                      : stall cycles since reset (wraps)
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MDU_LAT  = 4,
    parameter int unsigned REG_ADDR = 5
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [REG_ADDR-1:0] RsD,
    input  logic [REG_ADDR-1:0] RtD,
    input  logic [REG_ADDR-1:0] RsE,
    input  logic [REG_ADDR-1:0] RtE,
    input  logic [REG_ADDR-1:0] WriteRegE,
    input  logic [REG_ADDR-1:0] WriteRegM,
    input  logic [REG_ADDR-1:0] WriteRegW,
    input  logic                RegWriteE,
    input  logic                RegWriteM,
    input  logic                RegWriteW,
    input  logic                MemtoRegE,
    input  logic                MemtoRegM,
    input  logic                BranchD,
    input  logic                BranchTakenD,
    input  logic                MduStartE,
    input  logic                ImemReadyF,
    output logic                StallF,
    output logic                StallD,
    output logic                FlushD,
    output logic                FlushE,
    output logic [1:0]          ForwardAE,
    output logic [1:0]          ForwardBE,
    output logic                ForwardAD,
    output logic                ForwardBD,
    output logic                MduBusy,
    output logic [31:0]         StallCnt
);

    hz_state_t        state;
    logic [CNT_W-1:0] cnt;

    logic [1:0] fwd_ae, fwd_be;
    logic       fwd_ad, fwd_bd;
    logic       lw_e_rs, lw_e_rt, br_e, br_m;
    logic       lwstall, brstall, mdu_hold, hold;

    forward_unit #(.REG_ADDR(REG_ADDR)) u_fwd (
        .RsD       (RsD),
        .RtD       (RtD),
        .RsE       (RsE),
        .RtE       (RtE),
        .WriteRegM (WriteRegM),
        .WriteRegW (WriteRegW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (fwd_ae),
        .ForwardBE (fwd_be),
        .ForwardAD (fwd_ad),
        .ForwardBD (fwd_bd)
    );

    // Hazard detection; $zero specifiers never create a dependency.
    assign lw_e_rs = (WriteRegE != '0) && (WriteRegE == RsD);
    assign lw_e_rt = (WriteRegE != '0) && (WriteRegE == RtD);
    assign br_e    = lw_e_rs || lw_e_rt;
    assign br_m    = (WriteRegM != '0) && ((WriteRegM == RsD) || (WriteRegM == RtD));

    assign lwstall  = MemtoRegE && br_e;
    assign brstall  = BranchD && ((RegWriteE && br_e) || (MemtoRegM && br_m));
    assign mdu_hold = ((state == RUN) && MduStartE) || (state == MDU);
    assign hold     = lwstall || brstall || !ImemReadyF || mdu_hold;

    // Reset forces a flushed, non-stalled, non-forwarding pipeline.
    assign StallF    = !RST && hold;
    assign StallD    = !RST && hold;
    assign FlushE    = RST || hold;
    // IF/ID only honours CLR while not held, and an unresolved branch must not flush.
    assign FlushD    = RST || (BranchTakenD && !hold);
    assign ForwardAE = RST ? FWD_RF : fwd_ae;
    assign ForwardBE = RST ? FWD_RF : fwd_be;
    assign ForwardAD = !RST && fwd_ad;
    assign ForwardBD = !RST && fwd_bd;
    assign MduBusy   = !RST && mdu_hold;

    // MDU occupancy FSM and stall counter. The issue cycle is the first stall
    // cycle, so the counter is loaded with MDU_LAT-1 remaining cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= RUN;
            cnt      <= '0;
            StallCnt <= '0;
        end else begin
            if (hold) StallCnt <= StallCnt + 32'd1;
            if (state == RUN) begin
                if (MduStartE) begin
                    state <= MDU;
                    cnt   <= CNT_W'(MDU_LAT - 1);
                end
            end else begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed scoreboard bench for hazard_ctrl.
module tb_hazard_ctrl;

    localparam int unsigned MDU_LAT = 4;
    localparam int unsigned RA      = 5;

    typedef struct packed {
        logic          rst;
        logic [RA-1:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic          rw_e, rw_m, rw_w, m2r_e, m2r_m;
        logic          br_d, taken_d, mdu_start, imem_rdy;
    } stim_t;

    typedef struct packed {
        logic        stall_f, stall_d, flush_d, flush_e;
        logic [1:0]  fwd_ae, fwd_be;
        logic        fwd_ad, fwd_bd, mdu_busy;
        logic [31:0] stall_cnt;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [RA-1:0] RsD = '0, RtD = '0, RsE = '0, RtE = '0;
    logic [RA-1:0] WriteRegE = '0, WriteRegM = '0, WriteRegW = '0;
    logic          RegWriteE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
    logic          MemtoRegE = 1'b0, MemtoRegM = 1'b0;
    logic          BranchD = 1'b0, BranchTakenD = 1'b0;
    logic          MduStartE = 1'b0, ImemReadyF = 1'b1;
    logic          StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MduBusy;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [31:0]   StallCnt;

    hazard_ctrl #(.MDU_LAT(MDU_LAT), .REG_ADDR(RA)) dut (
        .CLK(CLK), .RST(RST),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .BranchTakenD(BranchTakenD),
        .MduStartE(MduStartE), .ImemReadyF(ImemReadyF),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .MduBusy(MduBusy), .StallCnt(StallCnt)
    );

    always #5 CLK = ~CLK;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Reference model state: stall cycles still owed to an MDU window, stall count.
    int unsigned m_rem = 0;
    logic [31:0] m_cnt = '0;

    function automatic bit hit(input logic [RA-1:0] dst, input logic [RA-1:0] src);
        return (dst != 0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwd_e(input stim_t s, input logic [RA-1:0] src);
        if (s.rw_m && hit(s.wr_m, src)) return 2'b10;
        if (s.rw_w && hit(s.wr_w, src)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.imem_rdy = 1'b1;
        return s;
    endfunction

    // Drive one cycle of stimulus and push the expected response.
    task automatic step(input stim_t s);
        exp_t e;
        bit   dep_e, lw, br, busy, hold;
        RST = s.rst; RsD = s.rs_d; RtD = s.rt_d; RsE = s.rs_e; RtE = s.rt_e;
        WriteRegE = s.wr_e; WriteRegM = s.wr_m; WriteRegW = s.wr_w;
        RegWriteE = s.rw_e; RegWriteM = s.rw_m; RegWriteW = s.rw_w;
        MemtoRegE = s.m2r_e; MemtoRegM = s.m2r_m;
        BranchD = s.br_d; BranchTakenD = s.taken_d;
        MduStartE = s.mdu_start; ImemReadyF = s.imem_rdy;

        e = '0;
        e.stall_cnt = m_cnt;
        if (s.rst) begin
            e.flush_d = 1'b1;
            e.flush_e = 1'b1;
            m_cnt = '0;
            m_rem = 0;
        end else begin
            dep_e = hit(s.wr_e, s.rs_d) || hit(s.wr_e, s.rt_d);
            lw    = s.m2r_e && dep_e;
            br    = s.br_d && ((s.rw_e && dep_e) ||
                               (s.m2r_m && (hit(s.wr_m, s.rs_d) || hit(s.wr_m, s.rt_d))));
            busy  = (m_rem > 0) || s.mdu_start;
            hold  = lw || br || !s.imem_rdy || busy;
            e.stall_f  = hold;
            e.stall_d  = hold;
            e.flush_e  = hold;
            e.flush_d  = s.taken_d && !hold;
            e.fwd_ae   = fwd_e(s, s.rs_e);
            e.fwd_be   = fwd_e(s, s.rt_e);
            e.fwd_ad   = s.rw_m && hit(s.wr_m, s.rs_d);
            e.fwd_bd   = s.rw_m && hit(s.wr_m, s.rt_d);
            e.mdu_busy = busy;
            if (hold) m_cnt = m_cnt + 1;
            if (m_rem > 0) m_rem = m_rem - 1;
            else if (s.mdu_start) m_rem = MDU_LAT - 1;
        end
        sbq.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cyc=%0d %s: got %0h expected %0h", cyc, name, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    always @(negedge CLK) begin : mon
        exp_t e;
        cyc++;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("StallF",    32'(StallF),    32'(e.stall_f));
            chk("StallD",    32'(StallD),    32'(e.stall_d));
            chk("FlushD",    32'(FlushD),    32'(e.flush_d));
            chk("FlushE",    32'(FlushE),    32'(e.flush_e));
            chk("ForwardAE", 32'(ForwardAE), 32'(e.fwd_ae));
            chk("ForwardBE", 32'(ForwardBE), 32'(e.fwd_be));
            chk("ForwardAD", 32'(ForwardAD), 32'(e.fwd_ad));
            chk("ForwardBD", 32'(ForwardBD), 32'(e.fwd_bd));
            chk("MduBusy",   32'(MduBusy),   32'(e.mdu_busy));
            chk("StallCnt",  StallCnt,       e.stall_cnt);
        end
    end

    initial begin : drive
        stim_t s;
        int    guard;
        @(posedge CLK);
        #1;
        s = idle(); s.rst = 1'b1;
        step(s); step(s);

        // Load-use: lw $t0 in E, consumer in D; then lw in M forwards to E.
        s = idle(); s.m2r_e = 1; s.rw_e = 1; s.wr_e = 8; s.rs_d = 8; s.taken_d = 1;
        step(s);
        s = idle(); s.rw_m = 1; s.m2r_m = 1; s.wr_m = 8; s.rs_e = 8;
        step(s);

        // Branch after ALU write, then decode forward with taken branch.
        s = idle(); s.br_d = 1; s.rs_d = 9; s.rw_e = 1; s.wr_e = 9;
        step(s);
        s = idle(); s.br_d = 1; s.taken_d = 1; s.rs_d = 9; s.rw_m = 1; s.wr_m = 9;
        step(s);

        // $zero guard.
        s = idle(); s.rw_m = 1; s.wr_m = 0; s.rs_e = 0; s.rs_d = 0; s.m2r_e = 1;
        step(s);

        // MDU window alone.
        s = idle(); s.mdu_start = 1; step(s);
        s = idle();
        for (int i = 0; i < 5; i++) step(s);

        // Imem wait 2..6 overlapping an MDU window started at 0.
        for (int i = 0; i < 9; i++) begin
            s = idle();
            s.mdu_start = (i == 0);
            s.imem_rdy  = !(i >= 2 && i <= 6);
            step(s);
        end

        // Reset two cycles into an MDU window.
        s = idle(); s.mdu_start = 1; step(s);
        s = idle(); step(s);
        s.rst = 1; step(s);
        s = idle(); step(s); step(s);

        // Randomized traffic on a small register range to force collisions.
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst       = ($urandom_range(0, 39) == 0);
            s.rs_d      = RA'($urandom_range(0, 3));
            s.rt_d      = RA'($urandom_range(0, 3));
            s.rs_e      = RA'($urandom_range(0, 3));
            s.rt_e      = RA'($urandom_range(0, 3));
            s.wr_e      = RA'($urandom_range(0, 3));
            s.wr_m      = RA'($urandom_range(0, 3));
            s.wr_w      = RA'($urandom_range(0, 3));
            s.rw_e      = 1'($urandom_range(0, 1));
            s.rw_m      = 1'($urandom_range(0, 1));
            s.rw_w      = 1'($urandom_range(0, 1));
            s.m2r_e     = ($urandom_range(0, 3) == 0);
            s.m2r_m     = ($urandom_range(0, 3) == 0);
            s.br_d      = ($urandom_range(0, 2) == 0);
            s.taken_d   = 1'($urandom_range(0, 1));
            s.mdu_start = ($urandom_range(0, 7) == 0);
            s.imem_rdy  = ($urandom_range(0, 4) != 0);
            step(s);
        end

        guard = 0;
        while (sbq.size() > 0 && guard < 10) begin
            @(negedge CLK);
            guard++;
        end
        #1;
        if (sbq.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses left, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
